pkt_mux_rr: RTL and testbench

N-to-1 packet multiplexer for the controller interactive path. It merges packet streams from `CHN_NUM` upstream producers, such as frame encapsulation and decapsulation, into one stream that writes a shared downstream FIFO. It uses round-robin arbitration at packet granularity. A packet is admitted only when the downstream FIFO can hold a maximum-length packet; otherwise the whole packet is discarded on the input side and counted.

---
 rtl/pkt_mux_rr.sv | 167 ++++++++++++++++
 tb/tb_pkt_mux_rr.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_mux_rr.sv
// N-to-1 packet multiplexer with packet-granular round-robin arbitration.
// Whole packets are admitted or discarded at the head depending on downstream FIFO room.
module pkt_mux_rr #(
  parameter int unsigned CHN_NUM        = 4,
  parameter int unsigned DW             = 134,
  parameter int unsigned FIFO_AW        = 9,
  parameter int unsigned MAX_PKT_CYCLES = 128,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CHN_NUM*DW-1:0] iv_data,
  input  logic [CHN_NUM-1:0]    iv_data_wr,
  input  logic [FIFO_AW-1:0]    iv_fifo_usedw,
  output logic [DW-1:0]         ov_data,
  output logic                  o_data_wr,
  output logic                  o_fifo_overflow_pulse,
  output logic [CHN_NUM-1:0]    ov_grant,
  output logic [CNT_W-1:0]      ov_overflow_cnt,
  output logic [CNT_W-1:0]      ov_collision_cnt
);

  localparam int unsigned CW = $clog2(CHN_NUM);
  localparam logic [FIFO_AW-1:0] ADMIT_TH = FIFO_AW'((2 ** FIFO_AW) - 1 - MAX_PKT_CYCLES);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  localparam logic [1:0] IDLE_S    = 2'd0;
  localparam logic [1:0] TRANS_S   = 2'd1;
  localparam logic [1:0] DISCARD_S = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [DW-1:0]      data_q, data_d;
  logic               wr_q, wr_d;
  logic               ovf_pulse_q, ovf_pulse_d;
  logic [CHN_NUM-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]   coll_cnt_q, coll_cnt_d;

  logic [DW-1:0]      chn_data [CHN_NUM];
  logic [1:0]         chn_tag  [CHN_NUM];
  logic [CHN_NUM-1:0] cand;
  logic               win_vld;
  logic [CW-1:0]      win_idx;
  logic               admit;
  logic [CHN_NUM-1:0] g_onehot;

  function automatic logic [3:0] popcnt(input logic [CHN_NUM-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < CHN_NUM; k++) c = c + 4'(v[k]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // A channel is a candidate when it presents a head or a single-cycle packet.
  always_comb begin
    for (int k = 0; k < CHN_NUM; k++) begin
      chn_data[k] = iv_data[k*DW +: DW];
      chn_tag[k]  = chn_data[k][DW-1:DW-2];
      cand[k]     = iv_data_wr[k] & chn_tag[k][0];
    end
  end

  // Scan from the highest offset down so the candidate nearest rr_ptr wins.
  always_comb begin
    logic [CW:0] pos;
    pos     = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = CHN_NUM - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr_q} + (CW + 1)'(i);
      if (pos >= (CW + 1)'(CHN_NUM)) pos = pos - (CW + 1)'(CHN_NUM);
      if (cand[pos[CW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = pos[CW-1:0];
      end
    end
  end

  assign admit    = (iv_fifo_usedw <= ADMIT_TH);
  assign g_onehot = CHN_NUM'(1) << gnt_idx_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    data_d      = '0;
    wr_d        = 1'b0;
    ovf_pulse_d = 1'b0;
    grant_d     = '0;
    ovf_cnt_d   = ovf_cnt_q;
    coll_cnt_d  = coll_cnt_q;
    case (state_q)
      IDLE_S: begin
        coll_cnt_d = sat_add(coll_cnt_q, popcnt(cand) - 4'(win_vld));
        if (win_vld) begin
          gnt_idx_d = win_idx;
          grant_d   = CHN_NUM'(1) << win_idx;
          rr_ptr_d  = (win_idx == CW'(CHN_NUM - 1)) ? '0 : win_idx + CW'(1);
          if (admit) begin
            data_d = chn_data[win_idx];
            wr_d   = 1'b1;
            if (chn_tag[win_idx] == TAG_HEAD) state_d = TRANS_S;
          end else begin
            ovf_pulse_d = 1'b1;
            ovf_cnt_d   = sat_add(ovf_cnt_q, 4'd1);
            if (chn_tag[win_idx] == TAG_HEAD) state_d = DISCARD_S;
          end
        end
      end
      TRANS_S: begin
        grant_d    = g_onehot;
        coll_cnt_d = sat_add(coll_cnt_q, popcnt(cand & ~g_onehot));
        wr_d       = iv_data_wr[gnt_idx_q];
        data_d     = iv_data_wr[gnt_idx_q] ? chn_data[gnt_idx_q] : '0;
        if (iv_data_wr[gnt_idx_q] && chn_tag[gnt_idx_q] == TAG_TAIL) state_d = IDLE_S;
      end
      DISCARD_S: begin
        grant_d    = g_onehot;
        coll_cnt_d = sat_add(coll_cnt_q, popcnt(cand & ~g_onehot));
        if (iv_data_wr[gnt_idx_q] && chn_tag[gnt_idx_q] == TAG_TAIL) state_d = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE_S;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      ovf_pulse_q <= 1'b0;
      grant_q     <= '0;
      ovf_cnt_q   <= '0;
      coll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      ovf_pulse_q <= ovf_pulse_d;
      grant_q     <= grant_d;
      ovf_cnt_q   <= ovf_cnt_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign ov_data               = data_q;
  assign o_data_wr             = wr_q;
  assign o_fifo_overflow_pulse = ovf_pulse_q;
  assign ov_grant              = grant_q;
  assign ov_overflow_cnt       = ovf_cnt_q;
  assign ov_collision_cnt      = coll_cnt_q;

endmodule

// File: tb/tb_pkt_mux_rr.sv
// Bench for pkt_mux_rr: directed scenarios with literal expectations plus randomized
// packet traffic checked every cycle against a packet-level reference model.
module tb_pkt_mux_rr;

  localparam int CHN  = 4;
  localparam int DW   = 134;
  localparam int AW   = 9;
  localparam int MAXP = 128;
  localparam int CNTW = 8;
  localparam int TH   = (1 << AW) - 1 - MAXP;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]     dat [CHN];
  logic [CHN-1:0]    wr;
  logic [AW-1:0]     usedw;
  logic [CHN*DW-1:0] iv_data;

  logic [DW-1:0]   ov_data;
  logic            o_data_wr;
  logic            o_pulse;
  logic [CHN-1:0]  ov_grant;
  logic [CNTW-1:0] ov_ovf_cnt;
  logic [CNTW-1:0] ov_coll_cnt;

  always_comb begin
    for (int k = 0; k < CHN; k++) iv_data[k*DW +: DW] = dat[k];
  end

  pkt_mux_rr #(
    .CHN_NUM       (CHN),
    .DW            (DW),
    .FIFO_AW       (AW),
    .MAX_PKT_CYCLES(MAXP),
    .CNT_W         (CNTW)
  ) u_dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .iv_data              (iv_data),
    .iv_data_wr           (wr),
    .iv_fifo_usedw        (usedw),
    .ov_data              (ov_data),
    .o_data_wr            (o_data_wr),
    .o_fifo_overflow_pulse(o_pulse),
    .ov_grant             (ov_grant),
    .ov_overflow_cnt      (ov_ovf_cnt),
    .ov_collision_cnt     (ov_coll_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: owner channel (-1 when free), discard flag, round-robin pointer.
  int             m_owner = -1;
  bit             m_disc  = 1'b0;
  int             m_ptr   = 0;
  logic [DW-1:0]  e_data  = '0;
  bit             e_wr    = 1'b0;
  bit             e_pulse = 1'b0;
  logic [CHN-1:0] e_grant = '0;
  int             e_ovf   = 0;
  int             e_coll  = 0;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic bit is_cand(input int k);
    return wr[k] && dat[k][DW-2];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_disc = 1'b0; m_ptr = 0;
    e_data = '0; e_wr = 1'b0; e_pulse = 1'b0; e_grant = '0; e_ovf = 0; e_coll = 0;
  endtask

  // Next registered outputs from the inputs presented for the coming clock edge.
  task automatic model_step();
    int n, w, k;
    logic [1:0] t;
    e_wr = 1'b0; e_data = '0; e_pulse = 1'b0; e_grant = '0;
    n = 0; w = -1;
    if (m_owner < 0) begin
      for (int off = 0; off < CHN; off++) begin
        k = (m_ptr + off) % CHN;
        if (is_cand(k)) begin
          n++;
          if (w < 0) w = k;
        end
      end
      if (w >= 0) begin
        e_coll  = sat(e_coll + n - 1);
        m_ptr   = (w + 1) % CHN;
        e_grant = CHN'(1 << w);
        t = dat[w][DW-1 -: 2];
        if (int'(usedw) <= TH) begin
          e_wr = 1'b1; e_data = dat[w];
        end else begin
          e_pulse = 1'b1; e_ovf = sat(e_ovf + 1);
        end
        if (t == 2'b01) begin
          m_owner = w;
          m_disc  = (int'(usedw) > TH);
        end
      end
    end else begin
      for (int j = 0; j < CHN; j++) if (j != m_owner && is_cand(j)) n++;
      e_coll  = sat(e_coll + n);
      e_grant = CHN'(1 << m_owner);
      if (!m_disc && wr[m_owner]) begin
        e_wr = 1'b1; e_data = dat[m_owner];
      end
      if (wr[m_owner] && dat[m_owner][DW-1 -: 2] == 2'b10) m_owner = -1;
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_data", ov_data, e_data);
    chk("cmp_wr", o_data_wr, e_wr);
    chk("cmp_pulse", o_pulse, e_pulse);
    chk("cmp_grant", ov_grant, e_grant);
    chk("cmp_ovf_cnt", ov_ovf_cnt, e_ovf);
    chk("cmp_coll_cnt", ov_coll_cnt, e_coll);
  end

  function automatic logic [DW-1:0] mk(input logic [1:0] tag);
    logic [DW-1:0] v;
    v = DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    v[DW-1:DW-2] = tag;
    return v;
  endfunction

  task automatic idle_all();
    wr = '0;
    for (int k = 0; k < CHN; k++) dat[k] = '0;
  endtask

  // Inputs are set before calling; returns just after the edge that registered them.
  task automatic step();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [DW-1:0] pk [10];
  int nw, np;
  int act [CHN];
  int rem [CHN];
  int r;

  initial begin
    usedw = '0;
    idle_all();
    model_reset();

    // Reset values and a 5-cycle packet on ch2.
    do_reset();
    chk("rst_wr", o_data_wr, 1'b0);
    chk("rst_grant", ov_grant, 4'b0000);
    chk("rst_ovf_cnt", ov_ovf_cnt, 0);
    chk("rst_coll_cnt", ov_coll_cnt, 0);
    pk[0] = mk(2'b01);
    for (int i = 1; i < 4; i++) pk[i] = mk(2'b00);
    pk[4] = mk(2'b10);
    for (int i = 0; i < 5; i++) begin
      idle_all(); wr[2] = 1'b1; dat[2] = pk[i];
      step();
      chk("t1_data", ov_data, pk[i]);
      chk("t1_grant", ov_grant, 4'b0100);
    end
    idle_all();
    step();
    chk("t1_grant_released", ov_grant, 4'b0000);
    chk("t1_wr_released", o_data_wr, 1'b0);
    // rr_ptr is now 3: ch3 beats ch0.
    idle_all(); wr = 4'b1001; dat[0] = mk(2'b11); dat[3] = mk(2'b11); pk[0] = dat[3];
    step();
    chk("t1_ptr3_grant", ov_grant, 4'b1000);
    chk("t1_ptr3_data", ov_data, pk[0]);
    chk("t1_ptr3_coll", ov_coll_cnt, 1);

    // Three simultaneous requesters served ch0, ch1, ch3.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle_all(); wr = 4'b1011;
      dat[0] = mk(2'b11); dat[1] = mk(2'b11); dat[3] = mk(2'b11);
      pk[c] = (c == 0) ? dat[0] : (c == 1) ? dat[1] : dat[3];
      step();
      chk("t2_grant", ov_grant, (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b1000);
      chk("t2_data", ov_data, pk[c]);
      if (c == 0) chk("t2_coll_first", ov_coll_cnt, 2);
    end
    chk("t2_coll_total", ov_coll_cnt, 6);

    // Refused 10-cycle packet at usedw=384, then admitted one at usedw=383.
    do_reset();
    nw = 0; np = 0;
    for (int i = 0; i < 11; i++) begin
      idle_all();
      usedw = (i == 0) ? AW'(384) : '0;
      if (i < 10) begin
        wr[1] = 1'b1;
        dat[1] = mk((i == 0) ? 2'b01 : (i == 9) ? 2'b10 : 2'b00);
      end
      step();
      nw += int'(o_data_wr); np += int'(o_pulse);
      if (i < 10) chk("t3_discard_grant", ov_grant, 4'b0010);
    end
    chk("t3_no_writes", nw, 0);
    chk("t3_one_pulse", np, 1);
    chk("t3_ovf_cnt", ov_ovf_cnt, 1);
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      idle_all();
      usedw = (i == 0) ? AW'(383) : AW'(511);
      wr[1] = 1'b1;
      dat[1] = mk((i == 0) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00);
      step();
      nw += int'(o_data_wr);
    end
    chk("t3_admit_writes", nw, 3);
    chk("t3_ovf_cnt_kept", ov_ovf_cnt, 1);

    // Back-to-back single-cycle packets on ch0.
    do_reset();
    usedw = '0;
    for (int i = 0; i < 8; i++) begin
      idle_all(); wr[0] = 1'b1; dat[0] = mk(2'b11); pk[0] = dat[0];
      step();
      chk("t4_wr", o_data_wr, 1'b1);
      chk("t4_data", ov_data, pk[0]);
    end
    idle_all();
    step();
    chk("t4_wr_after", o_data_wr, 1'b0);

    // ch1 head on ch0's tail cycle is lost; the next cycle's head is granted.
    do_reset();
    idle_all(); wr[0] = 1'b1; dat[0] = mk(2'b01); step();
    idle_all(); wr[0] = 1'b1; dat[0] = mk(2'b00); step();
    idle_all(); wr = 4'b0011; dat[0] = mk(2'b10); dat[1] = mk(2'b01); step();
    chk("t5_coll_on_tail", ov_coll_cnt, 1);
    idle_all(); wr[1] = 1'b1; dat[1] = mk(2'b11); pk[0] = dat[1]; step();
    chk("t5_next_grant", ov_grant, 4'b0010);
    chk("t5_next_wr", o_data_wr, 1'b1);
    chk("t5_next_data", ov_data, pk[0]);
    chk("t5_coll_final", ov_coll_cnt, 1);

    // Asynchronous reset in the middle of a ch2 packet.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_all(); wr[2] = 1'b1; dat[2] = mk((i == 0) ? 2'b01 : 2'b00); step();
    end
    chk("t6_pre_wr", o_data_wr, 1'b1);
    #2;
    idle_all();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_async_wr", o_data_wr, 1'b0);
    chk("t6_async_data", ov_data, '0);
    chk("t6_async_grant", ov_grant, 4'b0000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      idle_all(); wr[2] = 1'b1; dat[2] = mk((i == 2) ? 2'b10 : 2'b00); step();
      nw += int'(o_data_wr);
    end
    chk("t6_orphan_writes", nw, 0);
    idle_all(); wr[2] = 1'b1; dat[2] = mk(2'b01); pk[0] = dat[2]; step();
    chk("t6_head_wr", o_data_wr, 1'b1);
    chk("t6_head_data", ov_data, pk[0]);
    chk("t6_head_grant", ov_grant, 4'b0100);
    idle_all(); wr[2] = 1'b1; dat[2] = mk(2'b10); step();

    // Randomized traffic: mostly well-formed packets with gaps, some stray tags.
    do_reset();
    for (int k = 0; k < CHN; k++) begin
      act[k] = 0; rem[k] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom % 4);
      usedw = (r == 0) ? AW'(TH) : (r == 1) ? AW'(TH + 1) : AW'($urandom_range(0, 511));
      for (int k = 0; k < CHN; k++) begin
        wr[k] = 1'b0;
        dat[k] = mk(2'($urandom));
        if (act[k] != 0) begin
          if ($urandom % 4 != 0) begin
            wr[k] = 1'b1;
            if (rem[k] > 0) begin
              dat[k] = mk(2'b00); rem[k]--;
            end else begin
              dat[k] = mk(2'b10); act[k] = 0;
            end
          end
        end else begin
          r = int'($urandom % 20);
          if (r < 4) begin
            wr[k] = 1'b1; dat[k] = mk(2'b01); act[k] = 1; rem[k] = int'($urandom % 5);
          end else if (r < 7) begin
            wr[k] = 1'b1; dat[k] = mk(2'b11);
          end else if (r == 7) begin
            wr[k] = 1'b1;
          end
        end
      end
      step();
    end
    chk("rand_coll_saturated", ov_coll_cnt, CMAX);

    idle_all();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
